// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 frames, LSB first, with a one-byte holding buffer for back-to-back output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int STOP_BITS       = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       uart_transmit,
  output logic       busy
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BAUD_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (CYCLES_PER_BIT < 2) begin : g_badCyclesPerBit
    $error("uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_badStopBits
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            r_state;
  logic [BAUD_W-1:0] r_baudCount;
  logic [2:0]        r_bitIndex;
  logic              r_stopCount;
  logic [7:0]        r_shift;
  logic [7:0]        r_hold;
  logic              r_holdFull;
  logic              r_tx;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
  logic              w_parityNext;
`endif

  state_t            w_stateNext;
  logic [BAUD_W-1:0] w_baudNext;
  logic [2:0]        w_bitIndexNext;
  logic              w_stopNext;
  logic [7:0]        w_shiftNext;
  logic [7:0]        w_holdNext;
  logic              w_holdFullNext;
  logic              w_txNext;
  logic              w_accept;
  logic              w_bitEnd;
  logic              w_loadByte;
  logic [7:0]        w_loadValue;

  assign w_accept = data_in_valid && !r_holdFull;
  assign w_bitEnd = (r_baudCount == BAUD_LAST);

  always_comb begin
    w_stateNext    = r_state;
    w_baudNext     = w_bitEnd ? '0 : r_baudCount + BAUD_W'(1);
    w_bitIndexNext = r_bitIndex;
    w_stopNext     = r_stopCount;
    w_shiftNext    = r_shift;
    w_holdNext     = r_hold;
    w_holdFullNext = r_holdFull;
    w_loadByte     = 1'b0;
    w_loadValue    = data_in;
`ifdef UART_TX_PARITY_EN
    w_parityNext   = r_parity;
`endif

    case (r_state)
      IDLE: begin
        w_baudNext = '0;
        if (w_accept) begin
          w_loadByte  = 1'b1;
          w_stateNext = START;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_stateNext    = DATA;
          w_bitIndexNext = 3'd0;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_shiftNext    = {1'b0, r_shift[7:1]};
          w_bitIndexNext = r_bitIndex + 3'd1;
          w_stopNext     = 1'b0;
          if (r_bitIndex == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_stateNext = PARITY;
`else
            w_stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = STOP;
          w_stopNext  = 1'b0;
        end
      end
`endif
      STOP: begin
        if (w_bitEnd) begin
          if (r_stopCount == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (r_holdFull) begin
              w_loadByte     = 1'b1;
              w_loadValue    = r_hold;
              w_holdFullNext = 1'b0;
              w_stateNext    = START;
            end else if (w_accept) begin
              w_loadByte  = 1'b1;
              w_stateNext = START;
            end else begin
              w_stateNext = IDLE;
            end
          end else begin
            w_stopNext = r_stopCount + 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase

    if (w_loadByte) begin
      w_shiftNext    = w_loadValue;
      w_bitIndexNext = 3'd0;
`ifdef UART_TX_PARITY_EN
      w_parityNext   = ^w_loadValue;
`endif
    end

    if (w_accept && !w_loadByte) begin
      w_holdNext     = data_in;
      w_holdFullNext = 1'b1;
    end

    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txNext = w_parityNext;
`endif
      default: w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_baudCount <= '0;
      r_bitIndex  <= 3'd0;
      r_stopCount <= 1'b0;
      r_shift     <= 8'd0;
      r_hold      <= 8'd0;
      r_holdFull  <= 1'b0;
      r_tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_stateNext;
      r_baudCount <= w_baudNext;
      r_bitIndex  <= w_bitIndexNext;
      r_stopCount <= w_stopNext;
      r_shift     <= w_shiftNext;
      r_hold      <= w_holdNext;
      r_holdFull  <= w_holdFullNext;
      r_tx        <= w_txNext;
`ifdef UART_TX_PARITY_EN
      r_parity    <= w_parityNext;
`endif
    end
  end

  assign uart_transmit = r_tx;
  assign data_in_ready = !r_holdFull;
  assign busy          = (r_state != IDLE) || r_holdFull;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: one instance with one stop bit, one with two, checked each cycle
// against a frame-timing model, plus a bit-centre line decoder and a table of known frames.
module tb_uart_transmitter;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rstIn;
  logic       validIn [2];
  logic [7:0] dataIn  [2];
  logic       ready0, ready1, line0, line1, busy0, busy1;

  uart_transmitter #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .STOP_BITS(1)) dutOne (
    .clock(clock), .reset(rstIn), .data_in(dataIn[0]), .data_in_valid(validIn[0]),
    .data_in_ready(ready0), .uart_transmit(line0), .busy(busy0));

  uart_transmitter #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .STOP_BITS(2)) dutTwo (
    .clock(clock), .reset(rstIn), .data_in(dataIn[1]), .data_in_valid(validIn[1]),
    .data_in_ready(ready1), .uart_transmit(line1), .busy(busy1));

  typedef struct {
    bit         active;
    int         curStart;
    logic [7:0] curByte;
    bit         pending;
    logic [7:0] pendByte;
  } model_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] wireBits;
    logic       par;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         cycleNum = 0;
  int         resetCount = 0;
  model_t     mdl [2];
  bit         accepted [2];
  logic [7:0] expQ0[$], expQ1[$], rxQ0[$], rxQ1[$];
  logic [11:0] lastFrame [2];
  int         frameCount [2];

  function automatic int stopBitsOf(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int frameLen(input int d);
    return (10 + PAR + stopBitsOf(d) - 1) * CPB;
  endfunction

  // Wire bit k of a frame: start, eight data bits LSB first, optional parity, then stop bits.
  function automatic logic frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic getLine(input int d);
    return (d == 0) ? line0 : line1;
  endfunction
  function automatic logic getReady(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction
  function automatic logic getBusy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  task automatic checkInt(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d cycle %0d got %0h expected %0h", name, d, cycleNum, act, exp);
    end
  endtask

  task automatic modelStep(input int d);
    model_t m;
    logic   acc;
    m = mdl[d];
    acc = 1'b0;
    if (rstIn) begin
      m.active  = 1'b0;
      m.pending = 1'b0;
    end else begin
      acc = validIn[d] && !m.pending;
      if (m.active && cycleNum == m.curStart + frameLen(d)) begin
        if (d == 0) expQ0.push_back(m.curByte); else expQ1.push_back(m.curByte);
        if (m.pending) begin
          m.curByte  = m.pendByte;
          m.pending  = 1'b0;
          m.curStart = cycleNum;
        end else if (acc) begin
          m.curByte  = dataIn[d];
          m.curStart = cycleNum;
        end else begin
          m.active = 1'b0;
        end
      end else if (!m.active) begin
        if (acc) begin
          m.active   = 1'b1;
          m.curByte  = dataIn[d];
          m.curStart = cycleNum;
        end
      end else if (acc) begin
        m.pending  = 1'b1;
        m.pendByte = dataIn[d];
      end
    end
    accepted[d] = acc;
    mdl[d] = m;
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    cycleNum++;
    if (rstIn) resetCount++;
    for (int d = 0; d < 2; d++) modelStep(d);
  endtask

  task automatic checkOutput();
    model_t m;
    logic   expLine;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      m = mdl[d];
      expLine = m.active ? frameBit(m.curByte, (cycleNum - m.curStart) / CPB) : 1'b1;
      checkInt("line", d, 32'(getLine(d)), 32'(expLine));
      checkInt("ready", d, 32'(getReady(d)), 32'(!m.pending));
      checkInt("busy", d, 32'(getBusy(d)), 32'(m.active || m.pending));
    end
  endtask

  task automatic tick();
    applyStimulus();
    checkOutput();
  endtask

  // Host-side receiver: finds a start edge, samples every bit at its centre.
  task automatic decodeLoop(input int d);
    logic [11:0] fr;
    int          rc;
    int          nb;
    forever begin
      @(negedge clock);
      if (getLine(d) === 1'b0) begin
        rc = resetCount;
        fr = '1;
        nb = 10 + PAR + stopBitsOf(d) - 1;
        repeat (CPB / 2) @(negedge clock);
        fr[0] = getLine(d);
        for (int i = 1; i < nb; i++) begin
          repeat (CPB) @(negedge clock);
          fr[i] = getLine(d);
        end
        if (resetCount == rc) begin
          if (d == 0) rxQ0.push_back(fr[8:1]); else rxQ1.push_back(fr[8:1]);
          lastFrame[d] = fr;
          frameCount[d]++;
          checkInt("startBit", d, 32'(fr[0]), 32'd0);
`ifdef UART_TX_PARITY_EN
          checkInt("parityBit", d, 32'(fr[9]), 32'(^fr[8:1]));
`endif
          for (int s = 0; s < stopBitsOf(d); s++)
            checkInt("stopBit", d, 32'(fr[9 + PAR + s]), 32'd1);
        end
      end
    end
  endtask

  initial decodeLoop(0);
  initial decodeLoop(1);

  initial begin
    vec_t        tbl [8];
    logic [7:0]  b2b [5];
    logic [7:0]  s2 [2];
    logic [11:0] expW;
    int          idleBad, fc, idx0, idx1, acc1Cycle, off, highCnt, rxBefore0, rxBefore1, n;
    logic        nextStartLow;

    tbl[0] = '{8'h48, 10'b1_01001000_0, 1'b0};
    tbl[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
    tbl[2] = '{8'h03, 10'b1_00000011_0, 1'b0};
    tbl[3] = '{8'hA3, 10'b1_10100011_0, 1'b0};
    tbl[4] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    tbl[5] = '{8'h80, 10'b1_10000000_0, 1'b1};
    tbl[6] = '{8'h00, 10'b1_00000000_0, 1'b0};
    tbl[7] = '{8'h5A, 10'b1_01011010_0, 1'b0};
    b2b = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h00};
    s2  = '{8'h0F, 8'hF0};

    for (int d = 0; d < 2; d++) begin
      mdl[d].active = 1'b0; mdl[d].pending = 1'b0; mdl[d].curStart = 0;
      mdl[d].curByte = 8'd0; mdl[d].pendByte = 8'd0;
      validIn[d] = 1'b0; dataIn[d] = 8'd0; frameCount[d] = 0; lastFrame[d] = '1;
    end

    rstIn = 1'b1;
    repeat (3) tick();
    rstIn = 1'b0;
    checkInt("resetLine", 0, 32'(line0), 32'd1);
    checkInt("resetReady", 0, 32'(ready0), 32'd1);
    checkInt("resetBusy", 0, 32'(busy0), 32'd0);

    // Long idle with valid low: line, busy and ready must not move.
    idleBad = 0;
    repeat (1000) begin
      tick();
      if (line0 !== 1'b1 || busy0 !== 1'b0 || ready0 !== 1'b1) idleBad++;
    end
    checkInt("idle1000", 0, idleBad, 0);

    for (int i = 0; i < 8; i++) begin
      fc = frameCount[0];
      validIn[0] = 1'b1;
      dataIn[0] = tbl[i].data;
      tick();
      validIn[0] = 1'b0;
      repeat ((12 + PAR) * CPB) tick();
      checkInt("tableFrameSeen", 0, frameCount[0], fc + 1);
`ifdef UART_TX_PARITY_EN
      expW = {1'b1, 1'b1, tbl[i].par, tbl[i].wireBits[8:0]};
`else
      expW = {2'b11, tbl[i].wireBits};
`endif
      checkInt("tableWire", 0, 32'(lastFrame[0]), 32'(expW));
    end

    // Back-to-back bursts with valid held; dutTwo also measures its two-stop-bit gap.
    rxBefore0 = rxQ0.size();
    rxBefore1 = rxQ1.size();
    idx0 = 0; idx1 = 0; acc1Cycle = -1; highCnt = 0; nextStartLow = 1'b1;
    validIn[0] = 1'b1; dataIn[0] = b2b[0];
    validIn[1] = 1'b1; dataIn[1] = s2[0];
    repeat (5 * (10 + PAR) * CPB + 3 * CPB) begin
      tick();
      if (accepted[0]) idx0++;
      if (accepted[1]) begin
        if (idx1 == 0) acc1Cycle = cycleNum;
        idx1++;
      end
      if (acc1Cycle >= 0) begin
        off = cycleNum - acc1Cycle;
        if (off >= (9 + PAR) * CPB && off < (11 + PAR) * CPB && line1 === 1'b1) highCnt++;
        if (off == (11 + PAR) * CPB) nextStartLow = line1;
      end
      validIn[0] = (idx0 < 5);
      dataIn[0]  = (idx0 < 5) ? b2b[idx0] : 8'd0;
      validIn[1] = (idx1 < 2);
      dataIn[1]  = (idx1 < 2) ? s2[idx1] : 8'd0;
    end
    checkInt("b2bCount", 0, rxQ0.size() - rxBefore0, 5);
    if (rxQ0.size() - rxBefore0 >= 5)
      for (int i = 0; i < 5; i++) checkInt("b2bByte", 0, 32'(rxQ0[rxBefore0 + i]), 32'(b2b[i]));
    checkInt("stop2Count", 1, rxQ1.size() - rxBefore1, 2);
    if (rxQ1.size() - rxBefore1 >= 2)
      for (int i = 0; i < 2; i++) checkInt("stop2Byte", 1, 32'(rxQ1[rxBefore1 + i]), 32'(s2[i]));
    checkInt("stop2High", 1, highCnt, 20);
    checkInt("stop2NextStart", 1, 32'(nextStartLow), 32'd0);

    // Reset in the middle of 0x55 with 0x99 pending: both must be dropped.
    validIn[0] = 1'b1; dataIn[0] = 8'h55;
    tick();
    dataIn[0] = 8'h99;
    tick();
    validIn[0] = 1'b0;
    repeat (3 * CPB) tick();
    rstIn = 1'b1;
    tick();
    rstIn = 1'b0;
    checkInt("midResetLine", 0, 32'(line0), 32'd1);
    checkInt("midResetReady", 0, 32'(ready0), 32'd1);
    checkInt("midResetBusy", 0, 32'(busy0), 32'd0);
    repeat (15 * CPB) tick();
    fc = frameCount[0];
    validIn[0] = 1'b1; dataIn[0] = 8'hA3;
    tick();
    validIn[0] = 1'b0;
    repeat ((13 + PAR) * CPB) tick();
    checkInt("afterResetFrames", 0, frameCount[0], fc + 1);
    if (frameCount[0] == fc + 1) checkInt("afterResetByte", 0, 32'(rxQ0[$]), 32'h0A3);

    repeat (3000) begin
      for (int d = 0; d < 2; d++) begin
        validIn[d] = ($urandom_range(0, 3) != 0);
        dataIn[d]  = 8'($urandom);
      end
      tick();
    end

    validIn[0] = 1'b0; validIn[1] = 1'b0;
    n = 0;
    while ((mdl[0].active || mdl[0].pending || mdl[1].active || mdl[1].pending) && n < 3000) begin
      tick();
      n++;
    end
    checkInt("drainDone", 0, 32'(n < 3000), 32'd1);
    repeat (3 * CPB) tick();

    checkInt("rxCount", 0, rxQ0.size(), expQ0.size());
    for (int i = 0; i < rxQ0.size() && i < expQ0.size(); i++)
      checkInt("rxByte", 0, 32'(rxQ0[i]), 32'(expQ0[i]));
    checkInt("rxCount", 1, rxQ1.size(), expQ1.size());
    for (int i = 0; i < rxQ1.size() && i < expQ1.size(); i++)
      checkInt("rxByte", 1, 32'(rxQ1[i]), 32'(expQ1[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
